uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  Serialises words popped from the TX FIFO into asynchronous UART frames on tx_o.
//  Sits between the TX FIFO and the pin; paced by the 16x oversampling tick from the baud generator.
//  Frame format (data width, parity, stop bits) uses the UART_pkg codes DW_*, EVEN/ODD/DISABLED*, SB_*.
// PARAMETERS
//  OVERSAMPLE  16  ticks per bit period; must be a power of two; sets the tick counter width
// PORTS
//  clk_i            in   1  system clock
//  rst_n_i          in   1  asynchronous active-low reset
//  ov_baud_tick_i   in   1  one-cycle strobe at 16x the baud rate
//  tx_enable_i      in   1  gates new frames only; a frame in progress always completes
//  fifo_empty_i     in   1  TX FIFO empty
//  fifo_data_i      in   8  FIFO head word (first-word-fall-through; valid while !fifo_empty_i)
//  fifo_read_o      out  1  one-cycle pop strobe
//  data_width_i     in   2  DW_5BIT..DW_8BIT
//  parity_mode_i    in   2  EVEN / ODD / DISABLED1 / DISABLED2
//  stop_bits_i      in   2  SB_1BIT / SB_2BIT / RESERVED*
//  tx_o             out  1  serial line; idles high
//  tx_done_o        out  1  one-cycle pulse at the end of each frame (feeds INT_TX_DONE)
//  tx_idle_o        out  1  high in IDLE
// BEHAVIOUR
//  Reset values
//   - tx_o=1, fifo_read_o=0, tx_done_o=0, tx_idle_o=1.
//   - State IDLE; all counters and the shift register are cleared.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE|START
//  IDLE
//   - On any clk cycle with tx_enable_i & !fifo_empty_i (no tick needed):
//     - pulse fifo_read_o;
//     - latch fifo_data_i, data_width_i, parity_mode_i, stop_bits_i;
//     - clear the tick counter; go to START.
//   - Config inputs are ignored for the rest of the frame.
//  Bit timing
//   - tx_o is registered and changes the cycle after the state change.
//   - The tick counter increments on each ov_baud_tick_i.
//   - A bit ends on the tick where counter==OVERSAMPLE-1; the counter wraps to 0.
//   - Every bit therefore lasts exactly 16 ticks.
//  START: tx_o=0 for one bit.
//  DATA
//   - Sends N = 5 + data_width_i bits, LSB first, via a right-shift register and a 3-bit bit counter.
//   - Bits above N-1 are never transmitted.
//  PARITY
//   - Entered only for EVEN or ODD.
//   - EVEN: parity bit = XOR of the N sent bits. ODD: parity bit = inverted XOR of the N sent bits.
//   - DISABLED1/2: go DATA -> STOP directly.
//  STOP
//   - tx_o=1 for 1 bit (SB_1BIT) or 2 bits (SB_2BIT). RESERVED1/2 are treated as 1 bit.
//   - On the final tick of the last stop bit:
//     - pulse tx_done_o;
//     - if tx_enable_i & !fifo_empty_i, pop and latch a new word as in IDLE and go straight
//       to START (no idle gap);
//     - else go to IDLE.
//  Boundary conditions
//   - fifo_empty_i rising mid-frame: no effect.
//   - tx_enable_i dropped mid-frame: the frame finishes, then the block idles.
//   - ov_baud_tick_i during the IDLE pop cycle: ignored (counter cleared).
//   - Reset mid-frame: tx_o returns to 1 immediately (asynchronously); no tx_done_o; the partial
//     word is lost.
//  Latency
//   - Pop to start-bit: 1 clk.
//   - Frame length = (1 + N + P + S) * 16 ticks.
// TESTING
//  8E1, fifo_data_i=0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,0(parity),1; 176 ticks; one tx_done_o; one fifo_read_o.
//  5-bit ODD, 0x1F -> 0,1,1,1,1,1,0(parity),1; bits 7:5 never driven; 128 ticks.
//  7-bit DISABLED2, SB_2BIT, 0x7F -> no parity bit; 2 stop bits; 160 ticks total.
//  Two words queued, enable held -> second start bit immediately follows the first stop bit;
//   2 tx_done_o pulses, 2 fifo_read_o pulses.
//  Assert rst_n_i in the middle of DATA -> tx_o=1 same cycle, tx_idle_o=1, no tx_done_o.
//   Release: the next frame is clean.
//  Stop code RESERVED1, and config changed mid-frame -> 1 stop bit; the current frame uses the latched config.

Source files
------------

// File: rtl/uart_tx_engine.sv
// UART transmit serialiser: pops words from a first-word-fall-through FIFO and
// shifts out start/data/parity/stop bits, each held for OVERSAMPLE baud ticks.
module uart_tx_engine #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_tick_i,
  input  logic       tx_enable_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_read_o,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_i,
  output logic       tx_o,
  output logic       tx_done_o,
  output logic       tx_idle_o
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  localparam logic [1:0] PAR_EVEN = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] SB_2BIT  = 2'd1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]    last_bit_q, last_bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic          two_stop_q, two_stop_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          tx_q, tx_d;
  logic          read_q, read_d;
  logic          done_q, done_d;

  logic       pop_ok;
  logic       bit_end;
  logic [2:0] last_bit_new;
  logic [7:0] data_mask;

  assign pop_ok       = tx_enable_i & ~fifo_empty_i;
  assign bit_end      = ov_baud_tick_i & (cnt_q == CNT_LAST);
  assign last_bit_new = 3'd4 + {1'b0, data_width_i};

  // Parity covers only the bits that will actually be sent.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign data_mask[gi] = (3'(gi) <= last_bit_new);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    last_bit_d = last_bit_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    read_d     = 1'b0;
    done_d     = 1'b0;

    if (state_q != S_IDLE && ov_baud_tick_i) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == last_bit_q) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d    = S_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Load from IDLE, or chain straight into the next frame from the last stop tick.
    if ((state_q == S_IDLE || (state_q == S_STOP && done_d)) && pop_ok) begin
      read_d     = 1'b1;
      state_d    = S_START;
      cnt_d      = '0;
      shift_d    = fifo_data_i;
      last_bit_d = last_bit_new;
      par_en_d   = (parity_mode_i == PAR_EVEN) || (parity_mode_i == PAR_ODD);
      par_bit_d  = (^(fifo_data_i & data_mask)) ^ (parity_mode_i == PAR_ODD);
      two_stop_d = (stop_bits_i == SB_2BIT);
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= 3'd0;
      last_bit_q <= 3'd0;
      shift_q    <= 8'd0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      read_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      last_bit_q <= last_bit_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      read_q     <= read_d;
      done_q     <= done_d;
    end
  end

  assign tx_o        = tx_q;
  assign fifo_read_o = read_q;
  assign tx_done_o   = done_q;
  assign tx_idle_o   = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a monitor
// decodes tx_o mid-bit between each pop and done pulse and compares.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       en = 1'b0;
  logic       empty;
  logic [7:0] data;
  logic       rd;
  logic [1:0] dw = 2'd3;
  logic [1:0] pm = 2'd2;
  logic [1:0] sb = 2'd0;
  logic       tx;
  logic       done;
  logic       idle;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    bit          gap0;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] wq[$];
  int tests = 0;
  int fails = 0;
  int pops = 0;
  int dones = 0;
  bit active = 0;

  uart_tx_engine #(.OVERSAMPLE(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ov_baud_tick_i(tick), .tx_enable_i(en),
    .fifo_empty_i(empty), .fifo_data_i(data), .fifo_read_o(rd),
    .data_width_i(dw), .parity_mode_i(pm), .stop_bits_i(sb),
    .tx_o(tx), .tx_done_o(done), .tx_idle_o(idle)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction

  // Baud tick: one cycle in three.
  initial begin
    int div = 0;
    forever begin
      @(posedge clk); #1;
      div = (div + 1) % 3;
      tick = (div == 0);
    end
  end

  // FWFT FIFO model.
  initial begin
    empty = 1'b1;
    data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rd && wq.size() > 0) void'(wq.pop_front());
      empty = (wq.size() == 0);
      data  = empty ? 8'h00 : wq[0];
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t        cur;
    int          tcount = 0;
    logic [15:0] got_bits = '0;
    logic [15:0] m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
      end else begin
        if (done) begin
          dones++;
          if (!active) begin
            check("unexpected_done", 1, 0);
          end else begin
            m = 16'((32'd1 << cur.nbits) - 1);
            check("frame_ticks", tcount, cur.nbits * 16);
            check("frame_bits", int'(got_bits & m), int'(cur.bits));
            if (cur.gap0) check("no_gap_pop", int'(rd), 1);
            $display("[TB] frame %0d bits: got %h expected %h, %0d ticks",
                     cur.nbits, got_bits & m, cur.bits, tcount);
          end
          active = 0;
        end
        if (rd) begin
          pops++;
          if (exp_q.size() == 0) begin
            check("unexpected_pop", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            active = 1;
            tcount = 0;
            got_bits = '0;
          end
        end
        if (active && tick) begin
          if (tcount % 16 == 8 && tcount / 16 < 16) got_bits[tcount/16] = tx;
          tcount++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic [15:0] bits,
                      input int nbits, input bit gap0);
    exp_t e;
    e.bits = bits; e.nbits = nbits; e.gap0 = gap0;
    exp_q.push_back(e);
    wq.push_back(w);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    while ((exp_q.size() != 0 || active) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) check({name, "_timeout"}, 1, 0);
    @(posedge clk);
  endtask

  task automatic wait_pop(input string name);
    int n = 0;
    while (!rd && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({name, "_pop_timeout"}, 1, 0);
  endtask

  initial begin
    int p0, d0;
    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_read", int'(rd), 0);
    check("rst_done", int'(done), 0);
    check("rst_idle", int'(idle), 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b1;

    // 8E1 0xA5
    p0 = pops; d0 = dones;
    dw = 2'd3; pm = 2'd0; sb = 2'd0;
    send(8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 11, 0);
    wait_drain("8E1");
    check("8E1_pops", pops - p0, 1);
    check("8E1_dones", dones - d0, 1);

    // 5-bit ODD 0x1F
    dw = 2'd0; pm = 2'd1; sb = 2'd0;
    send(8'h1F, {1'b1, 1'b0, 5'h1F, 1'b0}, 8, 0);
    wait_drain("5O1");

    // 7-bit DISABLED2, two stop bits
    dw = 2'd2; pm = 2'd3; sb = 2'd1;
    send(8'h7F, {2'b11, 7'h7F, 1'b0}, 10, 0);
    wait_drain("7N2");

    // Two words back to back, 8N1
    p0 = pops; d0 = dones;
    dw = 2'd3; pm = 2'd2; sb = 2'd0;
    send(8'h3C, {1'b1, 8'h3C, 1'b0}, 10, 1);
    send(8'hC3, {1'b1, 8'hC3, 1'b0}, 10, 0);
    wait_drain("b2b");
    check("b2b_pops", pops - p0, 2);
    check("b2b_dones", dones - d0, 2);

    // Enable dropped mid-frame: current frame completes, next word stays queued
    send(8'h96, {1'b1, 8'h96, 1'b0}, 10, 0);
    wq.push_back(8'h69);
    @(negedge clk);
    wait_pop("en_drop");
    en = 1'b0;
    wait_drain("en_drop");
    repeat (200) @(negedge clk);
    check("en_drop_queued", wq.size(), 1);
    check("en_drop_idle", int'(idle), 1);
    begin
      exp_t e;
      e.bits = {1'b1, 8'h69, 1'b0}; e.nbits = 10; e.gap0 = 0;
      exp_q.push_back(e);
    end
    en = 1'b1;
    wait_drain("en_resume");

    // Reset in the middle of DATA
    d0 = dones;
    send(8'h00, {1'b1, 8'h00, 1'b0}, 10, 0);
    @(negedge clk);
    wait_pop("rst_mid");
    repeat (100) @(negedge clk);
    check("rst_mid_pre_tx", int'(tx), 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_idle", int'(idle), 1);
    check("rst_mid_done", int'(done), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_mid_no_done", dones - d0, 0);

    // Clean frame after reset: 6-bit EVEN 0x2A
    dw = 2'd1; pm = 2'd0; sb = 2'd0;
    send(8'h2A, {1'b1, 1'b1, 6'h2A, 1'b0}, 9, 0);
    wait_drain("6E1");

    // RESERVED1 stop code, config changed mid-frame
    dw = 2'd3; pm = 2'd1; sb = 2'd2;
    send(8'h81, {1'b1, 1'b1, 8'h81, 1'b0}, 11, 0);
    @(negedge clk);
    wait_pop("cfg_chg");
    dw = 2'd0; pm = 2'd0; sb = 2'd1;
    wait_drain("cfg_chg");
    check("final_idle", int'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
